// File: rtl/adder_sum_fifo_if.sv
// Stream bundle between the adder-side producer, the sum FIFO and its consumer.
// The master side produces sums and accepts results; the FIFO itself is the slave.
interface adder_sum_fifo_if #(
   parameter int DATA_WIDTH = 7
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/adder_sum_fifo.sv
// First-word-fall-through buffer for adder sums with occupancy flags and
// sticky drop detection. All outputs come straight from registers.
module adder_sum_fifo #(
   parameter int DATA_WIDTH = 7,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   adder_sum_fifo_if.slave              bus,
   input  logic                         clr_err,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         full,
   output logic                         empty,
   output logic                         overflow,
   output logic [CNT_WIDTH-1:0]         drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
   localparam logic [PW-1:0]         LVL_ZERO  = PW'(0);
   localparam logic [PW-1:0]         LVL_FULL  = PW'(DEPTH);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]         rd_ptr_r;
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         level_r;
   logic                  full_r;
   logic                  empty_r;
   logic                  out_valid_r;
   logic [DATA_WIDTH-1:0] out_data_r;
   logic                  overflow_r;
   logic [CNT_WIDTH-1:0]  drop_cnt_r;

   logic                  pop_s;
   logic                  push_s;
   logic                  drop_s;
   logic [PW-1:0]         rd_ptr_nxt_s;
   logic [PW-1:0]         wr_ptr_nxt_s;
   logic [PW-1:0]         level_nxt_s;
   logic [DATA_WIDTH-1:0] head_nxt_s;

   // Handshake decode and next-state pointer/level arithmetic.
   always_comb begin
      pop_s        = out_valid_r && bus.out_ready;
      push_s       = bus.in_valid && (!full_r || pop_s);
      drop_s       = bus.in_valid && full_r && !pop_s;
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      level_nxt_s  = level_r;
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + PTR_ONE;
         2'b01:   level_nxt_s = level_r - PTR_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Next head word; a lone freshly pushed word is forwarded since the array
   // write lands on the same edge as the output register update.
   always_comb begin
      head_nxt_s = DATA_ZERO;
      if (level_nxt_s == LVL_ZERO) begin
         head_nxt_s = DATA_ZERO;
      end else if (push_s && (level_nxt_s == PTR_ONE)) begin
         head_nxt_s = bus.in_data;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
      end
   end

   // Storage array write; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= bus.in_data;
      end
   end

   // Pointers, occupancy flags and the registered head word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_r    <= LVL_ZERO;
         wr_ptr_r    <= LVL_ZERO;
         level_r     <= LVL_ZERO;
         full_r      <= 1'b0;
         empty_r     <= 1'b1;
         out_valid_r <= 1'b0;
         out_data_r  <= DATA_ZERO;
      end else begin
         rd_ptr_r    <= rd_ptr_nxt_s;
         wr_ptr_r    <= wr_ptr_nxt_s;
         level_r     <= level_nxt_s;
         full_r      <= (level_nxt_s == LVL_FULL);
         empty_r     <= (level_nxt_s == LVL_ZERO);
         out_valid_r <= (level_nxt_s != LVL_ZERO);
         out_data_r  <= head_nxt_s;
      end
   end

   // Sticky drop tracking; a clear in the same cycle as a drop takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (clr_err) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (drop_s) begin
         overflow_r <= 1'b1;
         if (drop_cnt_r != CNT_MAX) begin
            drop_cnt_r <= drop_cnt_r + CNT_ONE;
         end else begin
            drop_cnt_r <= drop_cnt_r;
         end
      end else begin
         overflow_r <= overflow_r;
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign level         = level_r;
   assign full          = full_r;
   assign empty         = empty_r;
   assign overflow      = overflow_r;
   assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_adder_sum_fifo.sv
// Directed bench for adder_sum_fifo: reset, streaming, wrap, overflow,
// full-with-pop and error clear, with hand-computed expectations.
module tb_adder_sum_fifo;
   logic       clk;
   logic       reset;
   logic       clr_err;
   logic [3:0] level;
   logic       full;
   logic       empty;
   logic       overflow;
   logic [7:0] drop_cnt;

   int n_total;
   int n_bad;

   adder_sum_fifo_if #(.DATA_WIDTH(7)) bus ();

   adder_sum_fifo #(
      .DATA_WIDTH(7),
      .DEPTH     (8),
      .CNT_WIDTH (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .clr_err (clr_err),
      .level   (level),
      .full    (full),
      .empty   (empty),
      .overflow(overflow),
      .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_q[8];
      n_total = 0;
      n_bad   = 0;
      reset = 1'b1;
      clr_err = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 7'd0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // 1. reset mid-stream with three entries buffered
      for (int i = 1; i <= 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 7'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("pre_reset_level", level, 3);
      chk("pre_reset_head", bus.out_data, 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      tick();
      reset = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 7'd5;
      tick();
      bus.in_valid = 1'b0;
      chk("post_rst_valid", bus.out_valid, 1);
      chk("post_rst_data", bus.out_data, 5);
      chk("post_rst_level", level, 1);
      bus.out_ready = 1'b1;
      tick();
      chk("post_rst_drained", empty, 1);
      chk("empty_out_data", bus.out_data, 0);

      // 2. in-order streaming with the consumer always ready
      for (int i = 1; i <= 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 7'(i);
         tick();
         chk("stream_data", bus.out_data, i);
         chk("stream_valid", bus.out_valid, 1);
         chk("stream_level", level, 1);
      end
      bus.in_valid = 1'b0;
      tick();
      chk("stream_empty", empty, 1);
      chk("stream_valid_end", bus.out_valid, 0);

      // 3. fill to full, pop three, refill across pointer wrap
      bus.out_ready = 1'b0;
      for (int i = 10; i <= 17; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 7'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("fill_full", full, 1);
      chk("fill_level", level, 8);
      chk("fill_head", bus.out_data, 10);
      tick();
      chk("stall_head", bus.out_data, 10);
      bus.out_ready = 1'b1;
      for (int i = 11; i <= 13; i++) begin
         tick();
         chk("pop3_head", bus.out_data, i);
      end
      chk("pop3_level", level, 5);
      chk("pop3_not_full", full, 0);
      bus.out_ready = 1'b0;
      for (int i = 20; i <= 22; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 7'(i);
         tick();
      end
      chk("wrap_full", full, 1);
      chk("wrap_level", level, 8);

      // 4. drop while full, then saturate the drop counter
      bus.in_data = 7'd99;
      tick();
      chk("drop_overflow", overflow, 1);
      chk("drop_cnt_1", drop_cnt, 1);
      chk("drop_level", level, 8);
      chk("drop_head", bus.out_data, 13);
      bus.in_data = 7'd98;
      for (int i = 0; i < 300; i++) tick();
      chk("drop_cnt_sat", drop_cnt, 255);
      chk("sat_level", level, 8);

      // 5. push while full with a simultaneous pop
      bus.in_data = 7'd42;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("fullpop_level", level, 8);
      chk("fullpop_full", full, 1);
      chk("fullpop_overflow", overflow, 1);
      chk("fullpop_cnt", drop_cnt, 255);
      exp_q = '{14, 15, 16, 17, 20, 21, 22, 42};
      for (int i = 0; i < 8; i++) begin
         chk("drain_data", bus.out_data, exp_q[i]);
         chk("drain_level", level, 8 - i);
         tick();
      end
      chk("drain_empty", empty, 1);
      chk("drain_out_data", bus.out_data, 0);

      // 6. clear coinciding with a drop
      bus.out_ready = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_overflow", overflow, 0);
      chk("clr_cnt", drop_cnt, 0);
      for (int i = 30; i <= 37; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 7'(i);
         tick();
      end
      bus.in_data = 7'd70;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_clr_cnt", drop_cnt, 5);
      chk("pre_clr_overflow", overflow, 1);
      bus.in_data = 7'd77;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      bus.in_valid = 1'b0;
      chk("clrdrop_overflow", overflow, 0);
      chk("clrdrop_cnt", drop_cnt, 0);
      chk("clrdrop_level", level, 8);
      bus.out_ready = 1'b1;
      for (int i = 30; i <= 37; i++) begin
         chk("clr_drain_data", bus.out_data, i);
         tick();
      end
      chk("clr_drain_empty", empty, 1);
      bus.out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
